// File: rtl/hack_alu_pipe_pkg.sv
// Shared constants for the Hack ALU pipeline: ctrl bit positions, common opcodes, stage-1 payload.
// The optional overflow output is enabled by defining HACK_ALU_OVF_EN.
package hack_alu_pipe_pkg;

  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  localparam int ALU_MSB = 15;

  localparam logic [5:0] ALU_ZERO    = 6'b101010;
  localparam logic [5:0] ALU_ONE     = 6'b111111;
  localparam logic [5:0] ALU_NEG1    = 6'b111010;
  localparam logic [5:0] ALU_XPLUSY  = 6'b000010;
  localparam logic [5:0] ALU_XMINUSY = 6'b010011;
  localparam logic [5:0] ALU_XANDY   = 6'b000000;
  localparam logic [5:0] ALU_NOTX    = 6'b001101;

  typedef struct packed {
    logic [15:0] x1;
    logic [15:0] y1;
    logic        f;
    logic        no;
  } stage1_t;

endpackage

// File: rtl/hack_alu_pipe_gates.sv
// 16-bit bitwise gate cells (Not16, And16) used by the ALU datapath.

module Not16 (
  input  logic [15:0] i_in,
  output logic [15:0] o_out
);
  assign o_out = ~i_in;
endmodule

module And16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_out
);
  assign o_out = i_a & i_b;
endmodule

// File: rtl/hack_alu_pipe_preset.sv
// Combinational operand preset: optional zeroing followed by optional bitwise negation.

module alu16_preset (
  input  logic [15:0] i_d,
  input  logic        i_zero,
  input  logic        i_neg,
  output logic [15:0] o_d
);

  logic [15:0] w_zeroed;
  logic [15:0] w_negated;

  assign w_zeroed = i_zero ? 16'h0000 : i_d;

  Not16 u_not (
    .i_in  (w_zeroed),
    .o_out (w_negated)
  );

  assign o_d = i_neg ? w_negated : w_zeroed;

endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined 16-bit Hack ALU with valid/ready on both sides.
// Define HACK_ALU_OVF_EN to add the registered signed-overflow output ovf.

module hack_alu_pipe
  import hack_alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef HACK_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] w_x1;
  logic [WIDTH-1:0] w_y1;
  logic             w_s2Adv;
  logic             w_inAccept;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_rNeg;
  logic [WIDTH-1:0] w_out;

  stage1_t          r_s1;
  logic             r_s1Valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;
  logic             r_s2Valid;

  // Stage 1 moves forward whenever stage 2 is empty or draining this cycle.
  assign w_s2Adv    = r_s1Valid && (!r_s2Valid || out_ready);
  assign in_ready   = !r_s1Valid || w_s2Adv;
  assign w_inAccept = in_valid && in_ready;

  alu16_preset u_presetX (
    .i_d    (x),
    .i_zero (ctrl[CTRL_ZX]),
    .i_neg  (ctrl[CTRL_NX]),
    .o_d    (w_x1)
  );

  alu16_preset u_presetY (
    .i_d    (y),
    .i_zero (ctrl[CTRL_ZY]),
    .i_neg  (ctrl[CTRL_NY]),
    .o_d    (w_y1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= '0;
      r_s1Valid <= 1'b0;
    end else begin
      if (w_inAccept) begin
        r_s1.x1   <= w_x1;
        r_s1.y1   <= w_y1;
        r_s1.f    <= ctrl[CTRL_F];
        r_s1.no   <= ctrl[CTRL_NO];
        r_s1Valid <= 1'b1;
      end else if (w_s2Adv) begin
        r_s1Valid <= 1'b0;
      end
    end
  end

  And16 u_and (
    .i_a   (r_s1.x1),
    .i_b   (r_s1.y1),
    .o_out (w_and)
  );

  assign w_sum = r_s1.x1 + r_s1.y1;
  assign w_r   = r_s1.f ? w_sum : w_and;

  Not16 u_notOut (
    .i_in  (w_r),
    .o_out (w_rNeg)
  );

  assign w_out = r_s1.no ? w_rNeg : w_r;

  // Output registers only change on a stage-2 load, so they stay bit-stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_zr      <= 1'b0;
      r_ng      <= 1'b0;
      r_s2Valid <= 1'b0;
    end else begin
      if (w_s2Adv) begin
        r_out     <= w_out;
        r_zr      <= (w_out == '0);
        r_ng      <= w_out[ALU_MSB];
        r_s2Valid <= 1'b1;
      end else if (r_s2Valid && out_ready) begin
        r_s2Valid <= 1'b0;
      end
    end
  end

`ifdef HACK_ALU_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Overflow is judged on the raw sum, before the optional output negation.
  assign w_ovf = r_s1.f && (r_s1.x1[ALU_MSB] == r_s1.y1[ALU_MSB])
                        && (w_sum[ALU_MSB] != r_s1.x1[ALU_MSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_s2Adv) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

  assign out_valid = r_s2Valid;
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;

endmodule
